sseg_scan_display: RTL and testbench
====================================

Name: sseg_scan_display

Overview:
Parametrised, time-multiplexed hex display driver for N common-anode seven-segment digits. It succeeds the per-digit combinational hex decoder, which needs one decoder per digit. This block shares a single segment bus and scans the digits one at a time. It adds frame-atomic value updates, leading-zero blanking, per-digit blink and decimal points. It sits at the top level between the datapath output (or any debug bus) and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8); data width is 4*DIGITS.
SCAN_DIV, 1000, clock cycles each digit stays selected (>=1).
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
load  input  1  capture data_in/dp_in/blink_en this cycle.
data_in  input  4*DIGITS  hex value; nibble i drives digit i (digit 0 = least significant).
dp_in  input  DIGITS  decimal point enable per digit.
blink_en  input  DIGITS  blink enable per digit.
blank_lz  input  1  leading-zero blanking enable (level, sampled live).
seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
dp_out  output  1  decimal point, active-low, registered.
digit_sel  output  DIGITS  one-hot active-low digit enable, registered.
frame_start  output  1  one-cycle pulse when the scan wraps to digit 0.
pending  output  1  high while a captured value awaits commit.

Behaviour:
- Reset (asynchronous, any time including mid-frame) sets:
  - seg_out=7'h7F, dp_out=1, digit_sel all ones, frame_start=0, pending=0.
  - Prescaler, digit index idx, blink frame counter and blink_phase all 0.
  - Active and shadow data, dp and blink registers all 0.
- Prescaler counts 0..SCAN_DIV-1. At the terminal count (tick), idx advances modulo DIGITS.
- Frame boundary: tick with idx==DIGITS-1. On this cycle:
  - idx goes to 0.
  - frame_start pulses for 1 cycle, registered alongside the change of idx.
  - The blink counter increments. On reaching BLINK_FRAMES-1 it clears and blink_phase toggles.
- Outputs are registered from the current idx and active registers, so they lag idx by 1 clock.
  - First cycle after reset release: digit_sel = ~(1<<0), showing digit 0 of the active data.
- Load handshake (no back-pressure; load is always accepted):
  - load=1 copies data_in, dp_in and blink_en into the shadow registers and sets pending=1.
  - At the next frame boundary, shadow is copied to active and pending clears.
  - Multiple loads within one frame: the last one wins.
  - load on the frame-boundary cycle itself: inputs go directly to active and pending stays 0.
  - Net effect: a frame never mixes old and new digits.
- Decode of the active nibble, as hex values of {g..a}:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Leading-zero blanking: digit i>0 is blanked (seg_out=7F, dp_out=1) when blank_lz=1 and every active nibble at positions >=i is 0. Digit 0 is never blanked by this rule.
- Blink: when blink_en[i] (active) is set and blink_phase=1, digit i is blanked (seg_out=7F, dp_out=1). digit_sel still selects digit i.
- dp_out = ~dp[i] unless the digit is blanked by either rule.
- DIGITS=1: idx stays 0, and every tick is a frame boundary.
- SCAN_DIV=1: a tick occurs every cycle.

Test Plan:
1. Reset check (DIGITS=4, SCAN_DIV=4). Assert reset mid-stream.
   -> Outputs immediately: seg_out=7F, digit_sel=4'b1111, pending=0.
   -> One cycle after release: digit_sel=4'b1110, seg_out=40.
2. Basic display: load 16'h1A3F, then wait one frame.
   -> Digits 0..3 show 0E, 30, 08, 79.
   -> Each digit holds for 4 cycles with digit_sel 1110, 1101, 1011, 0111.
   -> frame_start pulses once every 16 cycles.
3. Leading-zero blanking, blank_lz=1:
   -> Load 16'h0050: digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40.
   -> Load 0: only digit 0 shows 40.
   -> Drop blank_lz: all digits show 40.
4. Frame atomicity: load 16'h1111 while idx=2, then load 16'h2222 while idx=3.
   -> pending=1 from the first load.
   -> Digits 2 and 3 still show the old value.
   -> At the boundary: frame_start=1, pending=0, and the whole next frame shows 24.
   -> Also load exactly on the boundary cycle: the value commits directly and pending never rises.
5. Blink: blink_en=4'b0100, dp_in=4'b0001, BLINK_FRAMES=2.
   -> Digit 2 alternates its value and 7F every 2 frames.
   -> Other digits stay steady.
   -> dp_out=0 only during digit 0.
6. Parameter sweep: DIGITS=1 and DIGITS=8, with SCAN_DIV=1.
   -> idx wraps correctly.
   -> digit_sel stays one-hot at every cycle.
   -> frame_start pulses every DIGITS cycles.

Source files
------------

// File: rtl/sseg_scan_display.sv
// sseg_scan_display
// Time-multiplexed hex driver for DIGITS common-anode seven-segment digits.
// One segment bus is shared and the digits are scanned one at a time, each
// held for SCAN_DIV clocks. New values are staged in shadow registers and
// swapped into the active set only on a frame boundary, so a frame never
// mixes old and new digits. Also supports leading-zero blanking, per-digit
// blink (half-period BLINK_FRAMES frames) and decimal points.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   load         capture data_in / dp_in / blink_en this cycle
//   data_in      hex value, nibble i -> digit i (digit 0 least significant)
//   dp_in        decimal point enable per digit
//   blink_en     blink enable per digit
//   blank_lz     leading-zero blanking enable (live level)
//   seg_out      segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_out       decimal point, active-low, registered
//   digit_sel    one-hot active-low digit enable, registered
//   frame_start  one-cycle pulse when the scan wraps to digit 0
//   pending      high while a captured value waits for the next frame
module sseg_scan_display #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  blank_lz,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [4*DIGITS-1:0]   act_data_q, act_data_d, sh_data_q, sh_data_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]     act_blink_q, act_blink_d, sh_blink_q, sh_blink_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic                  fs_q, fs_d;

    logic                  tick_s, boundary_s;
    logic [3:0]            nib_s;
    logic [DIGITS-1:0]     zero_from_s;  // bit i: all nibbles at positions >= i are zero
    logic                  run_s;
    logic                  lz_blank_s, blink_blank_s, blank_s;

    // Scan timing, blink timing and the shadow/active load handshake
    always_comb begin
        tick_s        = (presc_q == PRESC_LAST);
        boundary_s    = tick_s && (idx_q == IDX_LAST);
        presc_d       = presc_q;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        sh_data_d     = sh_data_q;
        sh_dp_d       = sh_dp_q;
        sh_blink_d    = sh_blink_q;
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        act_blink_d   = act_blink_q;
        pending_d     = pending_q;

        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (boundary_s) begin
            idx_d = {IW{1'b0}};
        end else if (tick_s) begin
            idx_d = idx_q + IW'(1);
        end else begin
            idx_d = idx_q;
        end

        if (boundary_s) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = {BW{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end

        if (load) begin
            sh_data_d  = data_in;
            sh_dp_d    = dp_in;
            sh_blink_d = blink_en;
        end else begin
            sh_data_d  = sh_data_q;
        end

        // A load on the boundary itself bypasses the shadow so it is not
        // held back a whole frame.
        if (boundary_s) begin
            pending_d = 1'b0;
            if (load) begin
                act_data_d  = data_in;
                act_dp_d    = dp_in;
                act_blink_d = blink_en;
            end else if (pending_q) begin
                act_data_d  = sh_data_q;
                act_dp_d    = sh_dp_q;
                act_blink_d = sh_blink_q;
            end else begin
                act_data_d  = act_data_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Pixel generation for the digit currently selected by idx_q
    always_comb begin
        nib_s = act_data_q[4*int'(idx_q) +: 4];
        run_s = 1'b1;
        zero_from_s = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_s          = run_s & (act_data_q[4*i +: 4] == 4'h0);
            zero_from_s[i] = run_s;
        end
        lz_blank_s    = blank_lz && (idx_q != {IW{1'b0}}) && zero_from_s[idx_q];
        blink_blank_s = act_blink_q[idx_q] && blink_phase_q;
        blank_s       = lz_blank_s || blink_blank_s;
        if (blank_s) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            seg_d = decode_hex(nib_s);
            dp_d  = ~act_dp_q[idx_q];
        end
        sel_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
        fs_d  = boundary_s;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= {PW{1'b0}};
            idx_q         <= {IW{1'b0}};
            blink_cnt_q   <= {BW{1'b0}};
            blink_phase_q <= 1'b0;
            act_data_q    <= {(4*DIGITS){1'b0}};
            act_dp_q      <= {DIGITS{1'b0}};
            act_blink_q   <= {DIGITS{1'b0}};
            sh_data_q     <= {(4*DIGITS){1'b0}};
            sh_dp_q       <= {DIGITS{1'b0}};
            sh_blink_q    <= {DIGITS{1'b0}};
            pending_q     <= 1'b0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            sel_q         <= {DIGITS{1'b1}};
            fs_q          <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_blink_q   <= act_blink_d;
            sh_data_q     <= sh_data_d;
            sh_dp_q       <= sh_dp_d;
            sh_blink_q    <= sh_blink_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            sel_q         <= sel_d;
            fs_q          <= fs_d;
        end
    end

    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign digit_sel   = sel_q;
    assign frame_start = fs_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Self-checking bench for sseg_scan_display: a 4-digit instance with
// SCAN_DIV=4 / BLINK_FRAMES=2, plus 1-digit and 8-digit instances with
// SCAN_DIV=1. Expected per-cycle outputs are queued and popped as the
// display scans.
module tb_sseg_scan_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    // 4-digit instance
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in, blink_en;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dpo, fs, pend;
    logic [3:0]  sel;
    // 1-digit instance
    logic        load1;
    logic [3:0]  data1;
    logic [0:0]  dp1, bl1, sel1;
    logic [6:0]  seg1;
    logic        dpo1, fs1, pend1;
    // 8-digit instance
    logic        load8;
    logic [31:0] data8;
    logic [7:0]  dp8, bl8, sel8;
    logic [6:0]  seg8;
    logic        dpo8, fs8, pend8;

    sseg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blink_en(blink_en), .blank_lz(blank_lz), .seg_out(seg), .dp_out(dpo),
        .digit_sel(sel), .frame_start(fs), .pending(pend));

    sseg_scan_display #(.DIGITS(1), .SCAN_DIV(1), .BLINK_FRAMES(2)) dut1 (
        .clk(clk), .reset(reset), .load(load1), .data_in(data1), .dp_in(dp1),
        .blink_en(bl1), .blank_lz(1'b0), .seg_out(seg1), .dp_out(dpo1),
        .digit_sel(sel1), .frame_start(fs1), .pending(pend1));

    sseg_scan_display #(.DIGITS(8), .SCAN_DIV(1), .BLINK_FRAMES(2)) dut8 (
        .clk(clk), .reset(reset), .load(load8), .data_in(data8), .dp_in(dp8),
        .blink_en(bl8), .blank_lz(1'b0), .seg_out(seg8), .dp_out(dpo8),
        .digit_sel(sel8), .frame_start(fs8), .pending(pend8));

    typedef struct {
        logic [7:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue one full 16-cycle frame of the 4-digit instance
    task automatic push4(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl,
                         input logic lz, input logic ph);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            logic [15:0] upper;
            logic blank;
            upper  = d >> (4 * i);
            blank  = (i > 0 && lz && upper == 16'h0) || (bl[i] && ph);
            e.sel  = {4'h0, ~(4'b0001 << i)};
            e.seg  = blank ? 7'h7F : dec(d[4*i +: 4]);
            e.dp   = blank ? 1'b1 : ~dpv[i];
            for (int c = 0; c < 4; c++) begin
                e.fs = (i == 3 && c == 3);
                q.push_back(e);
            end
        end
    endtask

    // Queue one 8-cycle frame of the 8-digit instance
    task automatic push8(input logic [31:0] d);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.sel = ~(8'h01 << i);
            e.seg = dec(d[4*i +: 4]);
            e.dp  = 1'b1;
            e.fs  = (i == 7);
            q.push_back(e);
        end
    endtask

    task automatic pop(input string tag, input int n, input int which);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            cyc(1);
            if (q.size() == 0) begin
                n_fail++;
                $error("FAIL %s underflow: observed empty queue expected entry", tag);
            end else begin
                e = q.pop_front();
                if (which == 8) begin
                    chk($sformatf("%s c%0d sel", tag, k), sel8, e.sel);
                    chk($sformatf("%s c%0d seg", tag, k), seg8, e.seg);
                    chk($sformatf("%s c%0d dp",  tag, k), dpo8, e.dp);
                    chk($sformatf("%s c%0d fs",  tag, k), fs8,  e.fs);
                end else begin
                    chk($sformatf("%s c%0d sel", tag, k), {4'h0, sel}, e.sel);
                    chk($sformatf("%s c%0d seg", tag, k), seg, e.seg);
                    chk($sformatf("%s c%0d dp",  tag, k), dpo, e.dp);
                    chk($sformatf("%s c%0d fs",  tag, k), fs,  e.fs);
                end
            end
        end
    endtask

    // Advance until frame_start (bounded), leaving time at the pulse cycle
    task automatic wait_fs(input string tag, input int which);
        int t;
        logic f;
        t = 0;
        f = 1'b0;
        while (!f && t < 100) begin
            cyc(1);
            t++;
            f = (which == 8) ? fs8 : fs;
        end
        chk({tag, " frame_start seen"}, f, 1'b1);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; data_in = 16'h0; dp_in = 4'h0; blink_en = 4'h0;
        blank_lz = 1'b0;
        load1 = 1'b0; data1 = 4'h0; dp1 = 1'b0; bl1 = 1'b0;
        load8 = 1'b0; data8 = 32'h0; dp8 = 8'h0; bl8 = 8'h0;
        cyc(2);
        reset = 1'b0;

        // 1. reset asserted mid-stream
        cyc(3);
        load = 1'b1; data_in = 16'h1234;
        cyc(1);
        load = 1'b0;
        chk("pre-reset pending", pend, 1'b1);
        cyc(22);
        reset = 1'b1;
        #1;
        chk("reset seg", seg, 7'h7F);
        chk("reset sel", sel, 4'b1111);
        chk("reset pending", pend, 1'b0);
        chk("reset dp", dpo, 1'b1);
        chk("reset fs", fs, 1'b0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("post-reset sel", sel, 4'b1110);
        chk("post-reset seg", seg, 7'h40);

        // 2. basic display
        load = 1'b1; data_in = 16'h1A3F;
        cyc(1);
        load = 1'b0;
        chk("basic pending", pend, 1'b1);
        push4(16'h1A3F, 4'h0, 4'h0, 1'b0, 1'b0);
        wait_fs("basic", 4);
        pop("basic", 16, 4);
        chk("basic pending clear", pend, 1'b0);

        // 3. leading-zero blanking
        blank_lz = 1'b1;
        load = 1'b1; data_in = 16'h0050;
        cyc(1);
        load = 1'b0;
        push4(16'h0050, 4'h0, 4'h0, 1'b1, 1'b0);
        wait_fs("lz0050", 4);
        pop("lz0050", 16, 4);
        load = 1'b1; data_in = 16'h0000;
        cyc(1);
        load = 1'b0;
        push4(16'h0000, 4'h0, 4'h0, 1'b1, 1'b0);
        wait_fs("lz0000", 4);
        pop("lz0000", 16, 4);
        blank_lz = 1'b0;
        push4(16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
        pop("nolz", 16, 4);

        // 4. frame atomicity
        cyc(8);
        load = 1'b1; data_in = 16'h1111;
        cyc(1);
        load = 1'b0;
        chk("atom pending1", pend, 1'b1);
        chk("atom sel2", sel, 4'b1011);
        chk("atom old d2", seg, 7'h40);
        cyc(3);
        load = 1'b1; data_in = 16'h2222;
        cyc(1);
        load = 1'b0;
        push4(16'h2222, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("atom pending2", pend, 1'b1);
        chk("atom sel3", sel, 4'b0111);
        chk("atom old d3", seg, 7'h40);
        cyc(3);
        chk("atom boundary fs", fs, 1'b1);
        chk("atom boundary pending", pend, 1'b0);
        pop("atom2222", 16, 4);
        cyc(15);
        chk("bnd pre pending", pend, 1'b0);
        load = 1'b1; data_in = 16'h5678;
        cyc(1);
        load = 1'b0;
        chk("bnd direct pending", pend, 1'b0);
        chk("bnd fs", fs, 1'b1);
        push4(16'h5678, 4'h0, 4'h0, 1'b0, 1'b0);
        pop("bnd5678", 16, 4);
        chk("bnd pending after", pend, 1'b0);

        // 5. blink (reset to align the blink counter)
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        load = 1'b1; data_in = 16'h1A3F; dp_in = 4'b0001; blink_en = 4'b0100;
        cyc(1);
        load = 1'b0;
        wait_fs("blink", 4);
        for (int k = 1; k <= 5; k++) begin
            push4(16'h1A3F, 4'b0001, 4'b0100, 1'b0, ((k / 2) % 2) == 1);
            pop($sformatf("blink f%0d", k), 16, 4);
        end

        // 6. parameter sweep: DIGITS=1 and DIGITS=8, SCAN_DIV=1
        load1 = 1'b1; data1 = 4'h9; dp1 = 1'b1;
        cyc(1);
        load1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk($sformatf("d1 c%0d sel", k), sel1, 1'b0);
            chk($sformatf("d1 c%0d seg", k), seg1, 7'h10);
            chk($sformatf("d1 c%0d dp", k), dpo1, 1'b0);
            chk($sformatf("d1 c%0d fs", k), fs1, 1'b1);
            chk($sformatf("d1 c%0d pending", k), pend1, 1'b0);
        end
        load8 = 1'b1; data8 = 32'h89AB_C0D7;
        cyc(1);
        load8 = 1'b0;
        push8(32'h89AB_C0D7);
        wait_fs("d8", 8);
        pop("d8 f0", 8, 8);
        push8(32'h89AB_C0D7);
        pop("d8 f1", 8, 8);
        chk("d8 pending", pend8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
